// File: rtl/i2c_slave_mem_bridge.sv
// EEPROM-style I2C slave: device address, pointer byte, burst writes and reads on a byte memory port.
// Latency: inputs pass 2-FF sync plus FILT_LEN filter; each memory access takes <=4 clk with a combinational ack.
// Backpressure: none on I2C (no clock stretching); the memory port waits on mem_ack. Optional: I2C_SLV_GCALL_EN.
module i2c_slave_mem_bridge #(
    parameter logic [6:0] SLV_ADDR = 7'h50,
    parameter int         FILT_LEN = 3
) (
    input  logic       clk,
    input  logic       resetb,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata,
    output logic       mem_wr,
    output logic       mem_en,
    input  logic       mem_ack,
    output logic       busy
);

    localparam int FW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK,
        RD_FETCH, RDATA, RACK, WAIT_STOP
    } state_t;

    typedef enum logic [1:0] {M_IDLE, M_SETUP, M_EN, M_DONE} mstate_t;

    // bit 0 = scl, bit 1 = sda
    logic [1:0] sync1, sync2, lvl, lvl_d;

    // two-flop synchronisers; the bus idles high
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            sync1 <= 2'b11;
            sync2 <= 2'b11;
        end else begin
            sync1 <= {sda_i, scl_i};
            sync2 <= sync1;
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_filt
        logic [FW-1:0] cnt;
        logic          flt;
        // accept a new level only after FILT_LEN consecutive samples that differ from the current one
        always_ff @(posedge clk or negedge resetb) begin
            if (!resetb) begin
                cnt <= '0;
                flt <= 1'b1;
            end else if (sync2[g] == flt) begin
                cnt <= '0;
            end else if (cnt == FW'(FILT_LEN - 1)) begin
                flt <= sync2[g];
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
        assign lvl[g] = flt;
    end

    // previous filtered levels for edge and START/STOP detection
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) lvl_d <= 2'b11;
        else         lvl_d <= lvl;
    end

    logic scl_rise, scl_fall, start_c, stop_c;
    assign scl_rise = lvl[0] & ~lvl_d[0];
    assign scl_fall = ~lvl[0] & lvl_d[0];
    assign start_c  = lvl[0] & lvl_d[0] & lvl_d[1] & ~lvl[1];
    assign stop_c   = lvl[0] & lvl_d[0] & ~lvl_d[1] & lvl[1];

    // ---------------- memory handshake ----------------
    mstate_t    mst, mst_n;
    logic       mreq, mreq_wr, mack;
    logic [7:0] mreq_adr, mreq_dat;

    // memory sequencer state register
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) mst <= M_IDLE;
        else         mst <= mst_n;
    end

    // setup one clk, enable until ack, one idle clk so address/data outlive mem_en
    always_comb begin
        mst_n = mst;
        case (mst)
            M_IDLE:  if (mreq) mst_n = M_SETUP;
            M_SETUP: mst_n = M_EN;
            M_EN:    if (mem_ack) mst_n = M_DONE;
            default: mst_n = M_IDLE;
        endcase
    end

    assign mack = (mst == M_EN) && mem_ack;

    // memory port registers; address/data latched only when a new access starts
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            mem_addr  <= 8'h00;
            mem_wdata <= 8'h00;
            mem_wr    <= 1'b0;
            mem_en    <= 1'b0;
        end else begin
            if (mst == M_IDLE && mreq) begin
                mem_addr  <= mreq_adr;
                mem_wdata <= mreq_dat;
                mem_wr    <= mreq_wr;
            end
            mem_en <= (mst_n == M_EN);
        end
    end

    // ---------------- protocol FSM ----------------
    state_t     state, state_n;
    logic [2:0] bitcnt, bitcnt_n;
    logic [7:0] shreg, shreg_n, ptr, ptr_n, byte_in;
    logic       sda_oe_n, busy_n, ack_on, ack_on_n, rw, rw_n, fetched, fetched_n, addr_hit;

    assign byte_in = {shreg[6:0], lvl[1]};
`ifdef I2C_SLV_GCALL_EN
    assign addr_hit = (byte_in[7:1] == SLV_ADDR) || (byte_in == 8'h00);
`else
    assign addr_hit = (byte_in[7:1] == SLV_ADDR);
`endif

    // protocol state and datapath registers
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state   <= IDLE;
            bitcnt  <= 3'd0;
            shreg   <= 8'h00;
            sda_oe  <= 1'b0;
            busy    <= 1'b0;
            ptr     <= 8'h00;
            ack_on  <= 1'b0;
            rw      <= 1'b0;
            fetched <= 1'b0;
        end else begin
            state   <= state_n;
            bitcnt  <= bitcnt_n;
            shreg   <= shreg_n;
            sda_oe  <= sda_oe_n;
            busy    <= busy_n;
            ptr     <= ptr_n;
            ack_on  <= ack_on_n;
            rw      <= rw_n;
            fetched <= fetched_n;
        end
    end

    // next state, bit shifting, ACK driving and memory requests
    always_comb begin
        state_n   = state;
        bitcnt_n  = bitcnt;
        shreg_n   = shreg;
        sda_oe_n  = sda_oe;
        busy_n    = busy;
        ptr_n     = ptr;
        ack_on_n  = ack_on;
        rw_n      = rw;
        fetched_n = fetched;
        mreq      = 1'b0;
        mreq_wr   = 1'b0;
        mreq_adr  = ptr;
        mreq_dat  = 8'h00;

        // a finished write advances the pointer even if the bus has moved on
        if (mack && mem_wr) ptr_n = ptr + 8'd1;
        if (mack && !mem_wr && state == RD_FETCH) begin
            shreg_n   = mem_rdata;
            fetched_n = 1'b1;
        end

        case (state)
            ADDR, PTR, WDATA: begin
                if (scl_rise) begin
                    shreg_n  = byte_in;
                    bitcnt_n = bitcnt + 3'd1;
                    if (bitcnt == 3'd7) begin
                        if (state == ADDR) begin
                            if (addr_hit) begin
                                state_n = ADDR_ACK;
                                rw_n    = byte_in[0];
                                busy_n  = 1'b1;
                            end else begin
                                state_n = WAIT_STOP;
                                busy_n  = 1'b0;
                            end
                        end else if (state == PTR) begin
                            ptr_n   = byte_in;
                            state_n = PTR_ACK;
                        end else begin
                            mreq     = 1'b1;
                            mreq_wr  = 1'b1;
                            mreq_dat = byte_in;
                            state_n  = WDATA_ACK;
                        end
                    end
                end
            end
            ADDR_ACK, PTR_ACK, WDATA_ACK: begin
                // first fall pulls SDA for the ACK slot, second fall releases it
                if (scl_fall) begin
                    if (!ack_on) begin
                        sda_oe_n = 1'b1;
                        ack_on_n = 1'b1;
                    end else begin
                        sda_oe_n = 1'b0;
                        ack_on_n = 1'b0;
                        bitcnt_n = 3'd0;
                        if (state == ADDR_ACK && rw) begin
                            state_n = RD_FETCH;
                            mreq    = 1'b1;
                        end else if (state == ADDR_ACK) begin
                            state_n = PTR;
                        end else begin
                            state_n = WDATA;
                        end
                    end
                end
            end
            RD_FETCH: begin
                // first data bit goes out only while SCL is low
                if (fetched && !lvl[0]) begin
                    sda_oe_n  = ~shreg[7];
                    fetched_n = 1'b0;
                    bitcnt_n  = 3'd0;
                    state_n   = RDATA;
                end
            end
            RDATA: begin
                if (scl_fall) begin
                    shreg_n  = {shreg[6:0], 1'b0};
                    sda_oe_n = ~shreg[6];
                end
                if (scl_rise) begin
                    bitcnt_n = bitcnt + 3'd1;
                    if (bitcnt == 3'd7) state_n = RACK;
                end
            end
            RACK: begin
                if (scl_fall) sda_oe_n = 1'b0;
                if (scl_rise) begin
                    if (!lvl[1]) begin
                        ptr_n    = ptr + 8'd1;
                        mreq     = 1'b1;
                        mreq_adr = ptr + 8'd1;
                        state_n  = RD_FETCH;
                    end else begin
                        busy_n  = 1'b0;
                        state_n = WAIT_STOP;
                    end
                end
            end
            default: ;
        endcase

        // bus conditions override everything; partial bytes are simply dropped
        if (stop_c) begin
            state_n   = IDLE;
            sda_oe_n  = 1'b0;
            busy_n    = 1'b0;
            ack_on_n  = 1'b0;
            fetched_n = 1'b0;
            bitcnt_n  = 3'd0;
        end else if (start_c) begin
            state_n   = ADDR;
            sda_oe_n  = 1'b0;
            ack_on_n  = 1'b0;
            fetched_n = 1'b0;
            bitcnt_n  = 3'd0;
        end
    end

endmodule

// File: tb/tb_i2c_slave_mem_bridge.sv
// Bench for i2c_slave_mem_bridge: bit-banged I2C master, byte memory model with combinational ack.
// Expected bus responses and memory accesses are queued by the stimulus and popped by monitors.
// Memory is preloaded with mem[i] = i ^ 8'hC3.
module tb_i2c_slave_mem_bridge;

    localparam int Q = 160;   // quarter SCL period = 16 clk

    logic       clk = 1'b0;
    logic       resetb = 1'b0;
    logic       scl = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_bus, sda_oe, mem_wr, mem_en, mem_ack, busy;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0] mem [256];

    logic [16:0] exp_mem [$];
    logic [7:0]  exp_bus [$];
    string       exp_nm  [$];
    logic [7:0]  obs_bus [$];
    int          vec = 0;
    int          err = 0;
    int          oe_cnt = 0;
    logic        en_q = 1'b0;

    assign sda_bus   = sda_m & ~sda_oe;
    assign mem_ack   = mem_en;
    assign mem_rdata = mem[mem_addr];

    always #5 clk = ~clk;

    i2c_slave_mem_bridge #(.SLV_ADDR(7'h50), .FILT_LEN(3)) dut (
        .clk(clk), .resetb(resetb), .scl_i(scl), .sda_i(sda_bus), .sda_oe(sda_oe),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_wr(mem_wr), .mem_en(mem_en), .mem_ack(mem_ack), .busy(busy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // memory monitor: checks each access start, commits writes on mem_en fall
    always @(negedge clk) begin
        logic [16:0] e;
        if (mem_en && !en_q) begin
            if (exp_mem.size() == 0) begin
                vec++;
                err++;
                $display("FAIL mem_unexpected: wr=%0d addr=%02h got an access, expected none", mem_wr, mem_addr);
            end else begin
                e = exp_mem.pop_front();
                chk("mem_wr", {31'd0, mem_wr}, {31'd0, e[16]});
                chk("mem_addr", {24'd0, mem_addr}, {24'd0, e[15:8]});
                if (e[16]) chk("mem_wdata", {24'd0, mem_wdata}, {24'd0, e[7:0]});
            end
        end
        if (en_q && !mem_en && mem_wr) mem[mem_addr] = mem_wdata;
        en_q = mem_en;
        if (sda_oe) oe_cnt++;
    end

    // bus monitor: compares what the master saw against queued expectations
    always @(negedge clk) begin
        logic [7:0] o;
        if (obs_bus.size() > 0) begin
            o = obs_bus.pop_front();
            if (exp_bus.size() == 0) begin
                vec++;
                err++;
                $display("FAIL bus_unexpected: got %02h expected nothing", o);
            end else begin
                chk(exp_nm.pop_front(), {24'd0, o}, {24'd0, exp_bus.pop_front()});
            end
        end
    end

    task automatic bitx(input logic b, output logic s);
        #(Q) sda_m = b;
        #(Q) scl = 1'b1;
        #(Q) s = sda_bus;
        #(Q) scl = 1'b0;
    endtask

    task automatic start_c;
        sda_m = 1'b1;
        #(Q) scl = 1'b1;
        #(Q) sda_m = 1'b0;
        #(Q) scl = 1'b0;
    endtask

    task automatic stop_c;
        #(Q) sda_m = 1'b0;
        #(Q) scl = 1'b1;
        #(Q) sda_m = 1'b1;
        #(Q);
    endtask

    task automatic wbyte(input logic [7:0] d, input logic exp_ack, input string nm);
        logic s;
        exp_bus.push_back({7'd0, exp_ack});
        exp_nm.push_back(nm);
        for (int i = 7; i >= 0; i--) bitx(d[i], s);
        bitx(1'b1, s);
        obs_bus.push_back({7'd0, s});
    endtask

    task automatic rbyte(input logic [7:0] exp_d, input logic mack, input string nm);
        logic s;
        logic [7:0] r;
        exp_bus.push_back(exp_d);
        exp_nm.push_back(nm);
        r = 8'h00;
        for (int i = 0; i < 8; i++) begin
            bitx(1'b1, s);
            r = {r[6:0], s};
        end
        obs_bus.push_back(r);
        bitx(mack, s);
    endtask

    task automatic exp_wr(input logic [7:0] a, input logic [7:0] d);
        exp_mem.push_back({1'b1, a, d});
    endtask

    task automatic exp_rd(input logic [7:0] a);
        exp_mem.push_back({1'b0, a, 8'h00});
    endtask

    initial begin
        logic s;
        int   o0;
        logic [7:0] part;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hC3;

        // reset values
        #(Q);
        chk("rst_sda_oe", {31'd0, sda_oe}, 0);
        chk("rst_mem_en", {31'd0, mem_en}, 0);
        chk("rst_mem_wr", {31'd0, mem_wr}, 0);
        chk("rst_mem_addr", {24'd0, mem_addr}, 0);
        chk("rst_mem_wdata", {24'd0, mem_wdata}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        resetb = 1'b1;
        #(Q);

        // burst write 0xA5, 0x5A at pointer 0x10
        start_c();
        wbyte(8'hA0, 1'b0, "t1_addr_ack");
        wbyte(8'h10, 1'b0, "t1_ptr_ack");
        exp_wr(8'h10, 8'hA5);
        wbyte(8'hA5, 1'b0, "t1_d0_ack");
        exp_wr(8'h11, 8'h5A);
        wbyte(8'h5A, 1'b0, "t1_d1_ack");
        chk("t1_busy_active", {31'd0, busy}, 1);
        stop_c();
        chk("t1_busy_after_stop", {31'd0, busy}, 0);
        chk("t1_mem10", {24'd0, mem[8'h10]}, 32'hA5);
        chk("t1_mem11", {24'd0, mem[8'h11]}, 32'h5A);

        // current-address read shows pointer advanced to 0x12
        start_c();
        wbyte(8'hA1, 1'b0, "t1r_addr_ack");
        exp_rd(8'h12);
        rbyte(8'hD1, 1'b1, "t1r_data_ptr12");
        stop_c();

        // pointer write, repeated START, two-byte read
        start_c();
        wbyte(8'hA0, 1'b0, "t2_addr_ack");
        wbyte(8'h10, 1'b0, "t2_ptr_ack");
        start_c();
        wbyte(8'hA1, 1'b0, "t2_raddr_ack");
        exp_rd(8'h10);
        exp_rd(8'h11);
        rbyte(8'hA5, 1'b0, "t2_rd0");
        rbyte(8'h5A, 1'b1, "t2_rd1");
        chk("t2_busy_after_nack", {31'd0, busy}, 0);
        stop_c();

        // wrong device: never ACKs, no accesses, never busy
        o0 = oe_cnt;
        start_c();
        wbyte(8'hA2, 1'b1, "t3_addr_nack");
        wbyte(8'h11, 1'b1, "t3_b0_nack");
        wbyte(8'h22, 1'b1, "t3_b1_nack");
        wbyte(8'h33, 1'b1, "t3_b2_nack");
        chk("t3_busy", {31'd0, busy}, 0);
        stop_c();
        chk("t3_sda_oe_cycles", oe_cnt - o0, 0);

        // pointer wrap 0xFF -> 0x00
        start_c();
        wbyte(8'hA0, 1'b0, "t4_addr_ack");
        wbyte(8'hFF, 1'b0, "t4_ptr_ack");
        exp_wr(8'hFF, 8'h11);
        wbyte(8'h11, 1'b0, "t4_d0_ack");
        exp_wr(8'h00, 8'h22);
        wbyte(8'h22, 1'b0, "t4_d1_ack");
        stop_c();
        chk("t4_memFF", {24'd0, mem[8'hFF]}, 32'h11);
        chk("t4_mem00", {24'd0, mem[8'h00]}, 32'h22);

        // STOP after 4 bits of a data byte discards it
        start_c();
        wbyte(8'hA0, 1'b0, "t5_addr_ack");
        wbyte(8'h30, 1'b0, "t5_ptr_ack");
        part = 8'hB4;
        for (int i = 7; i >= 4; i--) bitx(part[i], s);
        stop_c();
        chk("t5_sda_oe", {31'd0, sda_oe}, 0);
        chk("t5_mem30_kept", {24'd0, mem[8'h30]}, 32'hF3);
        start_c();
        wbyte(8'hA0, 1'b0, "t5b_addr_ack");
        wbyte(8'h30, 1'b0, "t5b_ptr_ack");
        exp_wr(8'h30, 8'h66);
        wbyte(8'h66, 1'b0, "t5b_d_ack");
        stop_c();
        chk("t5b_mem30", {24'd0, mem[8'h30]}, 32'h66);

        // reset in the middle of reading 0x83 from 0x40
        start_c();
        wbyte(8'hA0, 1'b0, "t7_addr_ack");
        wbyte(8'h40, 1'b0, "t7_ptr_ack");
        start_c();
        wbyte(8'hA1, 1'b0, "t7_raddr_ack");
        exp_rd(8'h40);
        bitx(1'b1, s);
        chk("t7_rd_bit7", {31'd0, s}, 1);
        #(Q) sda_m = 1'b1;
        #(Q) scl = 1'b1;
        #(Q / 2);
        chk("t7_sda_oe_driving", {31'd0, sda_oe}, 1);
        resetb = 1'b0;
        #1;
        chk("t7_rst_sda_oe", {31'd0, sda_oe}, 0);
        chk("t7_rst_mem_en", {31'd0, mem_en}, 0);
        chk("t7_rst_busy", {31'd0, busy}, 0);
        chk("t7_rst_mem_addr", {24'd0, mem_addr}, 0);
        #(Q) resetb = 1'b1;
        #(Q) scl = 1'b0;
        stop_c();

        // general call write, then general call read
        start_c();
`ifdef I2C_SLV_GCALL_EN
        wbyte(8'h00, 1'b0, "t6_gcall_ack");
        wbyte(8'h20, 1'b0, "t6_ptr_ack");
        exp_wr(8'h20, 8'h77);
        wbyte(8'h77, 1'b0, "t6_d_ack");
        stop_c();
        chk("t6_mem20", {24'd0, mem[8'h20]}, 32'h77);
`else
        wbyte(8'h00, 1'b1, "t6_gcall_nack");
        wbyte(8'h20, 1'b1, "t6_ptr_nack");
        wbyte(8'h77, 1'b1, "t6_d_nack");
        stop_c();
        chk("t6_mem20", {24'd0, mem[8'h20]}, 32'hE3);
`endif
        start_c();
        wbyte(8'h01, 1'b1, "t6_gcall_rd_nack");
        stop_c();

        #(2 * Q);
        chk("exp_mem_left", exp_mem.size(), 0);
        chk("exp_bus_left", exp_bus.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule

// File: doc/i2c_slave_mem_bridge.md
Name: i2c_slave_mem_bridge

Overview:
- Synchronous I2C slave front end that turns I2C bus transactions into byte accesses on an 8-bit async memory port (addr/wdata/rdata/wr/en/ack).
- Sits directly upstream of the slave-side byte memory model in the i2c_master_axi_lite test environment.
- Gives the AXI-Lite I2C master a real EEPROM-style target: pointer write, burst write, burst read, pointer auto-increment.

Parameters:
SLV_ADDR, 7'h50, 7-bit device address this slave acknowledges.
FILT_LEN, 3, number of consecutive equal samples needed to accept a new scl/sda level (glitch filter, >=1).

Ports:
clk  input  1  system clock; must be >= 16x SCL frequency.
resetb  input  1  asynchronous active-low reset.
scl_i  input  1  I2C clock from the bus pad (asynchronous).
sda_i  input  1  I2C data from the bus pad (asynchronous).
sda_oe  output  1  1 = pull SDA low (open drain); 0 = release.
mem_addr  output  8  memory byte address (current pointer).
mem_wdata  output  8  write data.
mem_rdata  input  8  read data, valid while mem_ack=1.
mem_wr  output  1  1 = write access, 0 = read access; stable for the whole access.
mem_en  output  1  access enable; a write commits on its falling edge.
mem_ack  input  1  memory acknowledge (may be combinational from mem_en).
busy  output  1  1 from an addressed START until STOP or NACK-terminated read.

Behaviour:
- Reset (asynchronous, resetb=0): sda_oe=0, mem_en=0, mem_wr=0, mem_addr=8'h00, mem_wdata=8'h00, busy=0, pointer=0, FSM=IDLE.
- Input conditioning:
  - scl_i and sda_i each pass through a 2-FF synchroniser, then the FILT_LEN filter.
  - Edge detection and START/STOP detection use the filtered levels only.
  - START: filtered SDA falls while SCL=1. STOP: filtered SDA rises while SCL=1.
- Bit timing: sample on SCL rise; change sda_oe only on SCL fall, one clk after the fall is detected. Bytes are MSB first.
- FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RD_FETCH, RDATA, RACK, WAIT_STOP.
- IDLE -> ADDR on START.
- ADDR, after 8 bits:
  - Address match: ACK (sda_oe=1 for one SCL low/high/low period), set busy=1. R/W=0 goes to PTR; R/W=1 goes to RD_FETCH.
  - Mismatch: no ACK, go to WAIT_STOP.
- PTR: the byte loads the pointer; ACK; then go to WDATA.
- WDATA, after 8 bits:
  - Issue a write of the byte to the pointer, then ACK.
  - pointer = pointer+1, modulo 256 (8'hFF wraps to 8'h00).
  - Further bytes repeat this until STOP or repeated START.
- RD_FETCH:
  - Read mem[pointer]; load it into the shift register.
  - RDATA drives the bit on each SCL fall; sda_oe = ~bit.
- RACK: release SDA and sample the master bit on SCL rise.
  - 0 (ACK): pointer+1 (wraps), then RD_FETCH.
  - 1 (NACK): go to WAIT_STOP with busy=0.
- Memory handshake (a sub-FSM shared by reads and writes):
  - Drive mem_addr, mem_wdata and mem_wr, then assert mem_en on the next clk.
  - Hold mem_en until mem_ack=1 is seen; capture mem_rdata on that clk for reads; deassert mem_en on the next clk.
  - mem_addr, mem_wr and mem_wdata stay stable until one clk after mem_en falls.
  - Each access holds mem_en for at least 1 clk and completes within 4 clk when ack is combinational.
  - No clock stretching.
- Repeated START in any state: go to ADDR; pointer retained.
- STOP in any state: go to IDLE, sda_oe=0, busy=0.
- START or STOP during a memory handshake: the handshake finishes (mem_en always falls after ack); the FSM transition is taken at the same time.
- Partial byte at STOP or repeated START: discarded, no memory write.
- Reset mid-transfer: immediate release of SDA; the memory port returns to its reset values.

Optional Feature:
- Macro: I2C_SLV_GCALL_EN.
- With the macro defined: address byte 8'h00 (general call, write) is ACKed and handled exactly like an own-address write (pointer byte, then data bytes). General-call read (8'h01) is NACKed.
- Without the macro: address 7'h00 is treated as a mismatch (NACK, WAIT_STOP).

Test Plan:
- Address 0xA0, bytes 0x10, 0xA5, 0x5A, then STOP -> three ACKs plus address ACK; mem[0x10]=0xA5, mem[0x11]=0x5A; pointer=0x12; busy falls at STOP.
- After the above: 0xA0, 0x10, repeated START, 0xA1, read 2 bytes with ACK then NACK -> SDA returns 0xA5 then 0x5A; busy=0 after the NACK.
- Address 0xA2 (wrong device) followed by 3 bytes -> SDA never pulled low; no mem_en pulses; busy stays 0.
- Pointer 0xFF, write 0x11, 0x22 -> mem[0xFF]=0x11, mem[0x00]=0x22.
- STOP after 4 bits of a data byte -> no memory write; sda_oe=0; FSM returns to IDLE; next transaction works normally. resetb pulse mid-read -> sda_oe=0, mem_en=0 within the reset assertion.
- Address 0x00, bytes 0x20, 0x77 -> with I2C_SLV_GCALL_EN: ACKs and mem[0x20]=0x77; without it: NACK and memory unchanged.
